// File: rtl/wb_trace_tx.sv
// Debug trace transmitter: queues register write-back events in a FIFO and
// sends each as a 4-byte record (A5, name, data hi, data lo) over an 8N1 line.
module wb_trace_tx #(
  parameter int DATA_W       = 16,
  parameter int NAME_W       = 4,
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     wb_i,
  input  logic [NAME_W-1:0]        wb_rd_name_i,
  input  logic [DATA_W-1:0]        wb_rd_data_i,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int ENT_W  = NAME_W + DATA_W;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [7:0]        SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             r_state;
  logic [ENT_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [ENT_W-1:0]   r_rec;
  logic [7:0]         r_shift;
  logic [BAUD_W-1:0]  r_baud;
  logic [2:0]         r_bit;
  logic [1:0]         r_byte;
  logic               r_tx;
  logic               r_busy;
  logic               r_ovf;

  logic               w_push;
  logic               w_push_ok;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic               w_baud_end;
  logic               w_tx_nxt;
  logic [ENT_W-1:0]   w_head;

  function automatic logic [7:0] rec_byte(input logic [ENT_W-1:0] rec, input logic [1:0] idx);
    case (idx)
      2'd0:    rec_byte = SYNC_BYTE;
      2'd1:    rec_byte = 8'(rec[ENT_W-1:DATA_W]);
      2'd2:    rec_byte = rec[15:8];
      default: rec_byte = rec[7:0];
    endcase
  endfunction

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_FULL);
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_push     = wb_i & en_i;
  // A pop happens either from IDLE or directly at the end of the last stop bit.
  assign w_pop      = !w_empty & ((r_state == S_IDLE) |
                      ((r_state == S_STOP) & w_baud_end & (r_byte == 2'd3)));
  assign w_push_ok  = w_push & (!w_full | w_pop);

  always_comb begin
    case (r_state)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = r_shift[r_bit];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= {wb_rd_name_i, wb_rd_data_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push & !w_push_ok) r_ovf <= 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Line and busy are registered from the current state, so both lag the FSM by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rec   <= '0;
      r_shift <= 8'h00;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_byte  <= 2'd0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_tx   <= w_tx_nxt;
      r_busy <= (r_state != S_IDLE) | !w_empty;
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (!w_empty) begin
            r_rec   <= w_head;
            r_shift <= SYNC_BYTE;
            r_byte  <= 2'd0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) r_state <= S_STOP;
            else               r_bit   <= r_bit + 3'd1;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_byte != 2'd3) begin
              r_byte  <= r_byte + 2'd1;
              r_shift <= rec_byte(r_rec, r_byte + 2'd1);
              r_state <= S_START;
            end else if (!w_empty) begin
              r_rec   <= w_head;
              r_shift <= SYNC_BYTE;
              r_byte  <= 2'd0;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_o       = r_tx;
  assign busy_o     = r_busy;
  assign overflow_o = r_ovf;
  assign count_o    = r_count;

endmodule

// File: tb/tb_wb_trace_tx.sv
// Bench for wb_trace_tx: directed and random write-back traffic compared each
// cycle against a record-level timing model of the serial trace stream.
`timescale 1ns/100ps
module tb_wb_trace_tx;
  localparam int C     = 4;
  localparam int DEPTH = 8;
  localparam int REC   = 40 * C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_i = 1'b0;
  logic        wb_i = 1'b0;
  logic [3:0]  wb_rd_name_i = 4'h0;
  logic [15:0] wb_rd_data_i = 16'h0000;
  logic        tx_o, busy_o, overflow_o;
  logic [3:0]  count_o;

  int errors = 0;
  int checks = 0;

  // Reference model: pending queue, edge index, earliest edge a pop may occur.
  logic [19:0] q[$];
  int          n, m_free, m_pop;
  logic [19:0] m_rec;
  bit          m_active, m_ovf;
  int          peak;

  wb_trace_tx #(.DATA_W(16), .NAME_W(4), .DEPTH(DEPTH), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .wb_i(wb_i),
    .wb_rd_name_i(wb_rd_name_i), .wb_rd_data_i(wb_rd_data_i),
    .tx_o(tx_o), .busy_o(busy_o), .overflow_o(overflow_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  // Line level k clocks into a record: 4 bytes of start, 8 data bits LSB first, stop.
  function automatic logic line_bit(input logic [19:0] rec, input int k);
    int bidx, slot;
    logic [7:0] b;
    bidx = k / (10 * C);
    slot = (k % (10 * C)) / C;
    case (bidx)
      0:       b = 8'hA5;
      1:       b = {4'h0, rec[19:16]};
      2:       b = rec[15:8];
      default: b = rec[7:0];
    endcase
    if (slot == 0)      line_bit = 1'b0;
    else if (slot == 9) line_bit = 1'b1;
    else                line_bit = b[slot-1];
  endfunction

  task automatic model_reset();
    q.delete();
    n = 0; m_free = 0; m_pop = 0; m_rec = '0; m_active = 0; m_ovf = 0;
  endtask

  task automatic step(input logic wb, input logic [3:0] nm, input logic [15:0] d);
    bit prev_active, pop;
    int prev_size, prev_pop;
    logic [19:0] prev_rec;
    logic exp_tx;
    @(negedge clk);
    wb_i = wb; wb_rd_name_i = nm; wb_rd_data_i = d;
    @(posedge clk);
    n++;
    prev_active = m_active; prev_size = q.size(); prev_pop = m_pop; prev_rec = m_rec;
    pop = (q.size() != 0) && (n >= m_free);
    if (pop) begin
      m_rec = q.pop_front(); m_pop = n; m_free = n + REC;
    end
    if (wb && en_i) begin
      if (q.size() < DEPTH) q.push_back({nm, d});
      else m_ovf = 1;
    end
    m_active = (n < m_free);
    exp_tx = prev_active ? line_bit(prev_rec, n - 1 - prev_pop) : 1'b1;
    #1;
    chk("tx", tx_o, exp_tx);
    chk("busy", busy_o, prev_active || prev_size != 0);
    chk("count", count_o, q.size());
    chk("overflow", overflow_o, m_ovf);
    if (int'(count_o) > peak) peak = count_o;
  endtask

  task automatic idle(input int cyc);
    for (int i = 0; i < cyc; i++) step(1'b0, 4'h0, 16'h0000);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", tx_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ovf", overflow_o, 1'b0);
    chk("rst_count", count_o, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    en_i = 1'b1;

    // Single event r3=0x1234.
    step(1'b1, 4'h3, 16'h1234);
    idle(REC + 10);

    // Three consecutive events; occupancy peaks at 2.
    peak = 0;
    step(1'b1, 4'h1, 16'h0001);
    step(1'b1, 4'h2, 16'hFFFF);
    step(1'b1, 4'hF, 16'h8000);
    idle(3 * REC + 10);
    chk("peak2", peak, 2);

    // Ten events while a record is in flight: fill to 8, two dropped.
    step(1'b1, 4'h7, 16'h0BEE);
    idle(20);
    for (int i = 0; i < 10; i++) step(1'b1, 4'(i), 16'($urandom));
    chk("full_count", count_o, 4'd8);
    chk("full_ovf", overflow_o, 1'b1);
    // Push landing exactly on the stop-to-start pop edge.
    for (int i = 0; i < 2 * REC && (n + 1) != m_free; i++) idle(1);
    chk("stop_edge_reached", (n + 1) == m_free, 1'b1);
    step(1'b1, 4'hC, 16'hC0DE);
    chk("full_pop_push_count", count_o, 4'd8);
    chk("full_pop_push_ovf", overflow_o, 1'b1);
    idle(9 * REC + 20);

    // Asynchronous reset mid-DATA of byte 2.
    step(1'b1, 4'h5, 16'h5A5A);
    idle(1 + 20 * C + C + 2);
    #2 rst = 1'b1;
    #0.5;
    chk("arst_tx", tx_o, 1'b1);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_ovf", overflow_o, 1'b0);
    chk("arst_count", count_o, 4'd0);
    #0.5 rst = 1'b0;
    model_reset();
    idle(REC);

    // Captures blocked while disabled, then r0=0x00AA.
    en_i = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 4'h9, 16'h1111);
    chk("dis_count", count_o, 4'd0);
    en_i = 1'b1;
    step(1'b1, 4'h0, 16'h00AA);
    idle(REC + 10);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      en_i = ($urandom_range(0, 7) != 0);
      step($urandom_range(0, 5) == 0, 4'($urandom), 16'($urandom));
    end
    en_i = 1'b1;
    for (int i = 0; i < (DEPTH + 2) * REC && (q.size() != 0 || m_active); i++) idle(1);
    idle(3);
    chk("drain_busy", busy_o, 1'b0);
    chk("drain_tx", tx_o, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_trace_tx.md
Name: wb_trace_tx

Overview:
- Debug trace transmitter inside core.
- Captures every register write-back event (wb, wb_rd_name, wb_rd_data on the EX-->RF path) into a small FIFO.
- Serializes each event as a 4-byte record over a UART-style 8N1 line to an off-chip host trace receiver.
- Lets silicon and FPGA builds report the same register activity the simulation bench prints per cycle.

Parameters:
- DATA_W, 16, write-back data width; fixed 16 for the 4-byte record format.
- NAME_W, 4, register name width (r0..rf).
- DEPTH, 8, FIFO entries; power of two, >= 2.
- CLKS_PER_BIT, 868, clocks per serial bit; >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en_i  in  1  trace enable; capture only when 1.
- wb_i  in  1  write-back valid this cycle.
- wb_rd_name_i  in  NAME_W  destination register name.
- wb_rd_data_i  in  DATA_W  data written.
- tx_o  out  1  serial line; idle high.
- busy_o  out  1  1 while a record is being shifted or the FIFO is non-empty.
- overflow_o  out  1  sticky: an event was dropped because the FIFO was full.
- count_o  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - tx_o=1, busy_o=0, overflow_o=0, count_o=0.
  - FIFO pointers cleared, FSM to IDLE, all counters 0.
  - A partially sent record is abandoned and never resumed.
- Capture:
  - Push on any rising edge where wb_i & en_i.
  - Entry = {wb_rd_name_i, wb_rd_data_i}.
  - One push per cycle maximum.
- Full FIFO:
  - A push when count=DEPTH and no pop in the same cycle is dropped and sets overflow_o.
  - If a pop occurs in the same cycle, the push is accepted and count stays DEPTH.
  - overflow_o clears only on rst.
- Record format, 4 bytes sent in order:
  - 0xA5 (sync).
  - {4'h0, name}.
  - data[15:8].
  - data[7:0].
- Framing per byte:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit lasts exactly CLKS_PER_BIT clocks.
  - One byte = 10*CLKS_PER_BIT clocks; one record = 40*CLKS_PER_BIT clocks.
  - Records are sent back-to-back with no idle gap between bytes or records.
- FSM states:
  - IDLE: tx_o=1. If FIFO non-empty, pop the head into a record register, byte index=0, go to START on the next edge. Pop happens in the IDLE cycle.
  - START: tx_o=0 for CLKS_PER_BIT clocks, then DATA with bit index 0.
  - DATA: tx_o=shift[bit]. After CLKS_PER_BIT clocks, advance the bit; after bit 7 go to STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT clocks. Then:
    - If byte index<3: increment and go to START.
    - Else if FIFO non-empty: pop, byte index=0, go to START directly with no IDLE cycle.
    - Else go to IDLE.
- Latency: first start-bit edge appears 2 clocks after the capture edge when idle (capture, IDLE pop, START).
- Counters:
  - Baud counter 0..CLKS_PER_BIT-1, wraps.
  - Bit counter 0..7; byte index 0..3.
  - FIFO read and write pointers wrap modulo DEPTH.
  - count_o = pushes minus pops, saturating at DEPTH by the drop rule.
- en_i:
  - Deasserting en_i blocks new captures only.
  - Queued entries and the in-flight record still complete.
- busy_o = (state != IDLE) | (count != 0), registered consistently with the state.
- Same-cycle push into an empty FIFO while IDLE: the entry is visible to IDLE on the next cycle; there is no bypass.

Test Plan:
- CLKS_PER_BIT=4; reset, then one wb of r3=0x1234 -> tx_o shows frames A5,03,12,34, LSB first, 160 clocks total; busy_o falls exactly after the last stop bit; overflow_o=0.
- Three consecutive wb cycles (r1=0x0001, r2=0xFFFF, rf=0x8000) -> 12 back-to-back bytes with no idle gap; count_o peaks at 2 (first entry popped immediately).
- DEPTH=8; 10 consecutive wb cycles while a record is in flight -> count_o reaches 8, overflow_o=1, exactly 9 records transmitted, the last two events missing.
- Full FIFO with a push in the same cycle as the STOP-to-START pop -> push accepted, count_o stays 8, overflow_o unchanged.
- Assert rst for 1 ns mid-DATA of byte 2 -> tx_o=1 and all outputs at reset values immediately, without waiting for a clock edge. After release with no new wb, tx_o stays high.
- en_i=0 with wb_i pulsed for 5 cycles -> no transmission, count_o=0. Set en_i=1 and pulse one wb of r0=0x00AA -> record A5,00,00,AA.
